// File: rtl/ram_port_arbiter_if.sv
// Bundles the fetch requester, load/store requester and RAM port signals seen by ram_port_arbiter.
interface ram_port_arbiter_if #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32
);
    logic                   FReq;
    logic [RAMAddrSize-1:0] FAddr;
    logic                   FAck;
    logic [dataW-1:0]       FData;
    logic                   FErr;

    logic                   DReq;
    logic                   DWrite;
    logic [RAMAddrSize-1:0] DAddr;
    logic [dataW-1:0]       DWData;
    logic                   DAck;
    logic [dataW-1:0]       DRData;
    logic                   DErr;

    logic                   Busy;

    logic [RAMAddrSize-1:0] RAMAddr;
    logic [dataW-1:0]       DataIn;
    logic                   RAMWriteControl;
    logic [dataW-1:0]       RAMOut;

    // Requesters and RAM model side
    modport master (
        output FReq, FAddr, DReq, DWrite, DAddr, DWData, RAMOut,
        input  FAck, FData, FErr, DAck, DRData, DErr, Busy,
        input  RAMAddr, DataIn, RAMWriteControl
    );

    // Arbiter side
    modport slave (
        input  FReq, FAddr, DReq, DWrite, DAddr, DWData, RAMOut,
        output FAck, FData, FErr, DAck, DRData, DErr, Busy,
        output RAMAddr, DataIn, RAMWriteControl
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin req/ack arbiter sharing one RAM port between fetch and load/store; IDLE->ACCESS->RESP,
// ack two cycles after the request is sampled; requesters hold req until ack, one access per 3 cycles.
module ram_port_arbiter #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32,
    parameter bit CheckAlign  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]             state;
    logic                   last_d;
    logic                   win_d;
    logic                   lat_we;
    logic                   lat_mis;
    logic [RAMAddrSize-1:0] lat_addr;
    logic [dataW-1:0]       lat_wdata;
    logic [dataW-1:0]       rdata_q;
    logic                   err_q;

    logic                   pick_d;
    logic                   pick_we;
    logic                   pick_mis;
    logic [RAMAddrSize-1:0] pick_addr;
    logic [dataW-1:0]       pick_wdata;

    logic                   in_access;
    logic                   in_resp;

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        pick_d     = bus.DReq & (~bus.FReq | ~last_d);
        pick_addr  = pick_d ? bus.DAddr : bus.FAddr;
        pick_we    = pick_d & bus.DWrite;
        pick_wdata = pick_d ? bus.DWData : '0;
        pick_mis   = CheckAlign && (pick_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            win_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.FReq || bus.DReq) begin
                        win_d     <= pick_d;
                        lat_addr  <= pick_addr;
                        lat_we    <= pick_we;
                        lat_wdata <= pick_wdata;
                        lat_mis   <= pick_mis;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= (lat_we || lat_mis) ? '0 : bus.RAMOut;
                    err_q   <= lat_mis;
                    state   <= RESP;
                end
                RESP: begin
                    last_d <= win_d;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_access = (state == ACCESS);
    // Reset suppresses both the RAM write strobe and the ack in the same cycle it is raised.
    assign in_resp   = (state == RESP) & ~reset;

    assign bus.RAMAddr         = in_access ? lat_addr  : '0;
    assign bus.DataIn          = in_access ? lat_wdata : '0;
    assign bus.RAMWriteControl = in_access & lat_we & ~lat_mis & ~reset;

    assign bus.FAck   = in_resp & ~win_d;
    assign bus.FData  = bus.FAck ? rdata_q : '0;
    assign bus.FErr   = bus.FAck & err_q;

    assign bus.DAck   = in_resp & win_d;
    assign bus.DRData = bus.DAck ? rdata_q : '0;
    assign bus.DErr   = bus.DAck & err_q;

    assign bus.Busy   = (state != IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: word RAM model behind the arbiter, vector table of single transactions, hand sequences.
module tb_ram_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_port_arbiter_if #(.dataW(32), .RAMAddrSize(32)) bus ();

    ram_port_arbiter #(.dataW(32), .RAMAddrSize(32), .CheckAlign(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // 64-word zero-delay RAM, preloaded with A500_0000 | word index
    logic [31:0] mem [0:63];
    assign bus.RAMOut = mem[bus.RAMAddr[7:2]];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.RAMWriteControl) begin
            mem[bus.RAMAddr[7:2]] <= bus.DataIn;
        end
    end

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_rwc;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.FReq   = 1'b0;
        bus.FAddr  = '0;
        bus.DReq   = 1'b0;
        bus.DWrite = 1'b0;
        bus.DAddr  = '0;
        bus.DWData = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rst_acks", {30'b0, bus.FAck, bus.DAck}, 32'd0);
        chk("rst_rwc", {31'b0, bus.RAMWriteControl}, 32'd0);
        chk("rst_addr", bus.RAMAddr, 32'd0);
        chk("rst_datain", bus.DataIn, 32'd0);
        chk("rst_rdata", bus.FData | bus.DRData, 32'd0);
        chk("rst_err", {30'b0, bus.FErr, bus.DErr}, 32'd0);
        @(posedge clock); #1;
        reset   = 1'b0;
        preload = 1'b0;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int          cyc = 0;
        int          rwc = 0;
        int          other = 0;
        int          lat = 0;
        logic        seen = 1'b0;
        logic        err = 1'b0;
        logic [31:0] data = '0;
        logic [31:0] acc_addr = '0;
        if (v.is_d) begin
            bus.DReq = 1'b1; bus.DWrite = v.wr; bus.DAddr = v.addr; bus.DWData = v.wdata;
        end else begin
            bus.FReq = 1'b1; bus.FAddr = v.addr;
        end
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (bus.RAMWriteControl) rwc++;
            if (cyc == 2) acc_addr = bus.RAMAddr;
            if (v.is_d ? bus.FAck : bus.DAck) other++;
            if (v.is_d ? bus.DAck : bus.FAck) begin
                seen = 1'b1;
                lat  = cyc;
                data = v.is_d ? bus.DRData : bus.FData;
                err  = v.is_d ? bus.DErr : bus.FErr;
            end
        end
        chk($sformatf("v%0d_ack_seen", idx), {31'b0, seen}, 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
        chk($sformatf("v%0d_data", idx), data, v.exp_data);
        chk($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_rwc_cycles", idx), 32'(rwc), 32'(v.exp_rwc));
        chk($sformatf("v%0d_ram_addr", idx), acc_addr, v.addr);
        chk($sformatf("v%0d_other_ack", idx), 32'(other), 32'd0);
        @(posedge clock); #1;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] exp_c [3];
        idle_inputs();

        //           is_d  wr    addr    wdata          exp_data       err   rwc
        tbl[0]  = '{1'b0, 1'b0, 32'd0,  32'd0,         32'hA500_0000, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 32'd64, 32'd90,        32'd0,         1'b0, 1};
        tbl[2]  = '{1'b1, 1'b0, 32'd64, 32'd0,         32'd90,        1'b0, 0};
        tbl[3]  = '{1'b1, 1'b1, 32'd66, 32'd91,        32'd0,         1'b1, 0};
        tbl[4]  = '{1'b1, 1'b0, 32'd64, 32'd0,         32'd90,        1'b0, 0};
        tbl[5]  = '{1'b0, 1'b0, 32'd66, 32'd0,         32'd0,         1'b1, 0};
        tbl[6]  = '{1'b0, 1'b0, 32'd64, 32'd0,         32'd90,        1'b0, 0};
        tbl[7]  = '{1'b1, 1'b0, 32'd67, 32'd0,         32'd0,         1'b1, 0};
        tbl[8]  = '{1'b1, 1'b1, 32'd4,  32'hDEAD_BEEF, 32'd0,         1'b0, 1};
        tbl[9]  = '{1'b0, 1'b0, 32'd4,  32'd0,         32'hDEAD_BEEF, 1'b0, 0};
        tbl[10] = '{1'b1, 1'b0, 32'd8,  32'd0,         32'hA500_0002, 1'b0, 0};

        do_reset();
        for (int i = 0; i < 11; i++) run_txn(i, tbl[i]);

        // Both requesters held from reset: F first, then alternating, acks every 3 cycles
        do_reset();
        bus.FReq = 1'b1; bus.FAddr = 32'd0;
        bus.DReq = 1'b1; bus.DWrite = 1'b0; bus.DAddr = 32'd8;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            chk($sformatf("rr_c%0d_fack", c), {31'b0, bus.FAck}, {31'b0, (c == 3 || c == 9)});
            chk($sformatf("rr_c%0d_dack", c), {31'b0, bus.DAck}, {31'b0, (c == 6 || c == 12)});
            if (c == 3) chk("rr_fdata", bus.FData, 32'hA500_0000);
            if (c == 6) chk("rr_drdata", bus.DRData, 32'hA500_0002);
        end
        @(posedge clock); #1;
        idle_inputs();

        // Fetch stream with address stepping at each ack
        do_reset();
        exp_c[0] = 32'hA500_0000;
        exp_c[1] = 32'hDEAD_BEEF;
        exp_c[2] = 32'hA500_0002;
        bus.FReq = 1'b1; bus.FAddr = 32'd0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            chk($sformatf("seq_c%0d_fack", c), {31'b0, bus.FAck}, {31'b0, (c % 3 == 0)});
            if (c % 3 == 2) begin
                chk($sformatf("seq_c%0d_busy", c), {31'b0, bus.Busy}, 32'd1);
                chk($sformatf("seq_c%0d_ramaddr", c), bus.RAMAddr, 32'((c / 3) * 4));
            end
            if (c % 3 == 0) begin
                chk($sformatf("seq_c%0d_fdata", c), bus.FData, exp_c[c / 3 - 1]);
                bus.FAddr = bus.FAddr + 32'd4;
            end
        end
        @(posedge clock); #1;
        idle_inputs();

        // Reset raised during the ACCESS cycle of a store: no write, no ack
        bus.DReq = 1'b1; bus.DWrite = 1'b1; bus.DAddr = 32'd68; bus.DWData = 32'd55;
        @(negedge clock);
        @(negedge clock);
        chk("rst_mid_busy_access", {31'b0, bus.Busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_rwc_gated", {31'b0, bus.RAMWriteControl}, 32'd0);
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk($sformatf("rst_mid_dack_%0d", c), {31'b0, bus.DAck}, 32'd0);
            chk($sformatf("rst_mid_busy_%0d", c), {31'b0, bus.Busy}, 32'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        run_txn(11, '{1'b1, 1'b0, 32'd68, 32'd0, 32'hA500_0011, 1'b0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
